// File: rtl/dmem_pkg.sv
// Shared constants and types for the MEM-stage data memory: RV32I load/store
// funct3 encodings, the controller FSM state type and a funct3 legality helper.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Stores only have signed encodings; loads add the unsigned byte/half forms.
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      if (we)
         return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatter: byte enables and replicated store data for a write,
// extended load data from the read word, and a natural-alignment flag.
module dmem_lane_fmt
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] st_data,
   input  logic [31:0] rd_word,
   output logic [3:0]  byte_en,
   output logic [31:0] wr_data,
   output logic [31:0] ld_data,
   output logic        misalign
);

   logic [1:0]  off;
   logic [31:0] rd_shift;

   // Offsets are always forced to natural alignment; misaligned accesses are
   // either errored upstream or meant to be silently aligned.
   always_comb begin
      off      = addr_lo;
      byte_en  = 4'b0000;
      wr_data  = st_data;
      misalign = 1'b0;
      case (funct3[1:0])
         2'b00: begin
            byte_en = 4'b0001 << addr_lo;
            wr_data = {4{st_data[7:0]}};
         end
         2'b01: begin
            off      = {addr_lo[1], 1'b0};
            byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
            wr_data  = {2{st_data[15:0]}};
            misalign = addr_lo[0];
         end
         default: begin
            off      = 2'b00;
            byte_en  = 4'b1111;
            misalign = |addr_lo;
         end
      endcase
   end

   assign rd_shift = rd_word >> {off, 3'b000};

   always_comb begin
      ld_data = rd_word;
      case (funct3[1:0])
         2'b00:   ld_data = funct3[2] ? {24'b0, rd_shift[7:0]}
                                      : {{24{rd_shift[7]}}, rd_shift[7:0]};
         2'b01:   ld_data = funct3[2] ? {16'b0, rd_shift[15:0]}
                                      : {{16{rd_shift[15]}}, rd_shift[15:0]};
         default: ld_data = rd_word;
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data memory with valid/ready handshake, WAIT_CYCLES wait states and
// RV32I sub-word access. Define DMEM_MISALIGN_CHK_EN to error misaligned accesses.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int DEPTH_LOG2  = 6,
   parameter int WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int AW    = DEPTH_LOG2 + 2;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [31:0]       mem [DEPTH];

   logic              acc_we;
   logic [2:0]        acc_f3;
   logic [AW-1:0]     acc_addr;
   logic [31:0]       acc_wdata;
   logic              acc_err;
   logic              do_access;
   logic              wr_en;
   logic [DEPTH_LOG2-1:0] idx;
   logic [31:0]       rd_word;
   logic [3:0]        byte_en;
   logic [31:0]       wr_data;
   logic [31:0]       ld_data;
   logic              misalign;
   logic              unused_bits;

   // With no wait states the access uses the live request on the acceptance edge.
   assign acc_we    = (state_q == IDLE) ? req_we            : we_q;
   assign acc_f3    = (state_q == IDLE) ? req_funct3        : f3_q;
   assign acc_addr  = (state_q == IDLE) ? req_addr[AW-1:0]  : addr_q;
   assign acc_wdata = (state_q == IDLE) ? req_wdata         : wdata_q;

   assign idx     = acc_addr[AW-1:2];
   assign rd_word = mem[idx];

`ifdef DMEM_MISALIGN_CHK_EN
   assign acc_err = !f3_legal(acc_we, acc_f3) || misalign;
`else
   assign acc_err = !f3_legal(acc_we, acc_f3);
`endif

   assign do_access = ((state_q == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                      ((state_q == WAIT) && (cnt_q == 4'd0));
   assign wr_en     = rst_n && do_access && acc_we && !acc_err;

   assign unused_bits = ^{req_addr[31:AW], misalign};

   dmem_lane_fmt u_fmt (
      .funct3   (acc_f3),
      .addr_lo  (acc_addr[1:0]),
      .st_data  (acc_wdata),
      .rd_word  (rd_word),
      .byte_en  (byte_en),
      .wr_data  (wr_data),
      .ld_data  (ld_data),
      .misalign (misalign)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               addr_d  = req_addr[AW-1:0];
               wdata_d = req_wdata;
               if (WAIT_CYCLES == 0) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 4'(WAIT_CYCLES - 1);
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (do_access) begin
         rdata_d = (acc_we || acc_err) ? 32'd0 : ld_data;
         err_d   = acc_err;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Storage is deliberately not reset; unselected lanes keep their contents.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: one instance with no wait states, one with three, both
// checked against a byte-array reference model of the RV32I load/store rules.
module tb_dmem_ctrl;

   localparam int W1 = 3;

   logic        clk = 1'b0;
   logic        rst_n       [2];
   logic        req_valid   [2];
   logic        req_ready   [2];
   logic        req_we      [2];
   logic [2:0]  req_funct3  [2];
   logic [31:0] req_addr    [2];
   logic [31:0] req_wdata   [2];
   logic        rsp_valid   [2];
   logic [31:0] rsp_rdata   [2];
   logic        rsp_err     [2];

   logic [7:0]  mdl [2][256];
   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit [31:0] rd;
      bit        er;
      int        lat;
      bit        rdy_low;
      bit        after_ok;
   } obs_t;

   typedef struct {
      bit        we;
      bit [2:0]  f3;
      bit [31:0] addr;
      bit [31:0] wdata;
      bit [31:0] exp;
   } vec_t;

   always #5 clk = ~clk;

   dmem_ctrl #(.DEPTH_LOG2(6), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
      .rsp_err(rsp_err[0]));

   dmem_ctrl #(.DEPTH_LOG2(6), .WAIT_CYCLES(W1)) dut1 (
      .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
      .rsp_err(rsp_err[1]));

   function automatic int wc(input int d);
      return (d == 0) ? 0 : W1;
   endfunction

   // Reference: 256-byte little-endian memory, address taken modulo its size.
   function automatic void model_access(input int d, input bit we, input bit [2:0] f3,
                                        input bit [31:0] a, input bit [31:0] wd,
                                        output bit [31:0] rd, output bit er);
      int size, base;
      bit legal, mis;
      bit [31:0] v;
      size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      legal = we ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      mis   = (int'(a[1:0]) % size) != 0;
`ifdef DMEM_MISALIGN_CHK_EN
      er = !legal || mis;
`else
      er = !legal;
`endif
      rd = 32'd0;
      if (er) return;
      base = int'(a[7:0]) - (int'(a[1:0]) % size);
      if (we) begin
         for (int k = 0; k < size; k++) mdl[d][base + k] = 8'(wd >> (8 * k));
      end else begin
         v = 32'd0;
         for (int k = 0; k < size; k++) v = v | (32'(mdl[d][base + k]) << (8 * k));
         if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | (32'hFFFF_FFFF << (8 * size));
         rd = v;
      end
   endfunction

   // Called at #1 after an edge; returns at #1 after the edge following RESP.
   task automatic do_req(input int d, input bit we, input bit [2:0] f3,
                         input bit [31:0] a, input bit [31:0] wd, output obs_t o);
      int guard = 0;
      req_valid[d] = 1'b1; req_we[d] = we; req_funct3[d] = f3;
      req_addr[d] = a; req_wdata[d] = wd;
      while (!req_ready[d] && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      o.lat = 1; o.rdy_low = 1'b1;
      while (!rsp_valid[d] && o.lat < 40) begin
         if (req_ready[d]) o.rdy_low = 1'b0;
         @(posedge clk); #1; o.lat++;
      end
      if (req_ready[d]) o.rdy_low = 1'b0;
      o.rd = rsp_rdata[d]; o.er = rsp_err[d];
      @(posedge clk); #1;
      o.after_ok = !rsp_valid[d] && req_ready[d];
      $display("txn dut%0d we=%0d f3=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
               d, we, f3, a, wd, o.rd, o.er, o.lat);
   endtask

   task automatic test_reset();
      for (int d = 0; d < 2; d++) begin
         rst_n[d] = 1'b0; req_valid[d] = 1'b1; req_we[d] = 1'b1;
         req_funct3[d] = 3'd2; req_addr[d] = 32'h0; req_wdata[d] = 32'hFFFF_FFFF;
      end
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'd0 || rsp_err[d] !== 1'b0 ||
                req_ready[d] !== 1'b1) begin
               failures++;
               $display("FAIL reset dut%0d valid=%b rdata=%h err=%b ready=%b required 0/0/0/1",
                        d, rsp_valid[d], rsp_rdata[d], rsp_err[d], req_ready[d]);
            end
         end
      end
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0; rst_n[d] = 1'b1;
      end
      @(posedge clk); #1;
   endtask

   task automatic init_mem();
      obs_t o;
      bit [31:0] r;
      bit e;
      for (int d = 0; d < 2; d++) begin
         for (int w = 0; w < 64; w++) begin
            do_req(d, 1'b1, 3'd2, 32'(4 * w), 32'd0, o);
            model_access(d, 1'b1, 3'd2, 32'(4 * w), 32'd0, r, e);
         end
      end
   endtask

   task automatic test_directed();
      vec_t v [12];
      obs_t o;
      bit [31:0] r;
      bit e;
      v[0]  = '{1'b1, 3'd2, 32'h10, 32'h1234_5678, 32'h0};
      v[1]  = '{1'b0, 3'd2, 32'h10, 32'h0,         32'h1234_5678};
      v[2]  = '{1'b1, 3'd2, 32'h10, 32'h80FF_7F01, 32'h0};
      v[3]  = '{1'b0, 3'd0, 32'h13, 32'h0,         32'hFFFF_FF80};
      v[4]  = '{1'b0, 3'd4, 32'h13, 32'h0,         32'h0000_0080};
      v[5]  = '{1'b0, 3'd1, 32'h12, 32'h0,         32'hFFFF_80FF};
      v[6]  = '{1'b0, 3'd5, 32'h10, 32'h0,         32'h0000_7F01};
      v[7]  = '{1'b1, 3'd2, 32'h10, 32'h0,         32'h0};
      v[8]  = '{1'b1, 3'd0, 32'h11, 32'h0000_00AA, 32'h0};
      v[9]  = '{1'b0, 3'd2, 32'h10, 32'h0,         32'h0000_AA00};
      v[10] = '{1'b1, 3'd1, 32'h12, 32'h0000_BEEF, 32'h0};
      v[11] = '{1'b0, 3'd2, 32'h10, 32'h0,         32'hBEEF_AA00};
      for (int i = 0; i < 12; i++) begin
         do_req(0, v[i].we, v[i].f3, v[i].addr, v[i].wdata, o);
         model_access(0, v[i].we, v[i].f3, v[i].addr, v[i].wdata, r, e);
         checks++;
         if (o.rd !== v[i].exp || o.er !== 1'b0) begin
            failures++;
            $display("FAIL directed[%0d] rdata=%h err=%b required rdata=%h err=0",
                     i, o.rd, o.er, v[i].exp);
         end
         checks++;
         if (o.lat !== 1 || !o.rdy_low || !o.after_ok) begin
            failures++;
            $display("FAIL directed_timing[%0d] lat=%0d rdy_low=%b after_ok=%b required 1/1/1",
                     i, o.lat, o.rdy_low, o.after_ok);
         end
      end
   endtask

   task automatic test_misalign();
      obs_t o;
      bit [31:0] r;
      bit e;
      do_req(0, 1'b1, 3'd2, 32'h22, 32'hCAFE_F00D, o);
      model_access(0, 1'b1, 3'd2, 32'h22, 32'hCAFE_F00D, r, e);
      checks++;
      if (o.er !== e || o.rd !== 32'd0) begin
         failures++;
         $display("FAIL misalign_sw err=%b rdata=%h required err=%b rdata=0", o.er, o.rd, e);
      end
      do_req(0, 1'b0, 3'd2, 32'h20, 32'h0, o);
      model_access(0, 1'b0, 3'd2, 32'h20, 32'h0, r, e);
      checks++;
      if (o.rd !== r || o.er !== 1'b0) begin
         failures++;
         $display("FAIL misalign_readback rdata=%h err=%b required rdata=%h err=0", o.rd, o.er, r);
      end
      do_req(0, 1'b0, 3'd3, 32'h20, 32'h0, o);
      checks++;
      if (o.er !== 1'b1 || o.rd !== 32'd0) begin
         failures++;
         $display("FAIL illegal_load err=%b rdata=%h required err=1 rdata=0", o.er, o.rd);
      end
   endtask

   task automatic test_random(input int d, input int n);
      obs_t o;
      bit [31:0] r, a, wd;
      bit e, we;
      bit [2:0] f3;
      for (int i = 0; i < n; i++) begin
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         wd = $urandom;
         do_req(d, we, f3, a, wd, o);
         model_access(d, we, f3, a, wd, r, e);
         checks++;
         if (o.rd !== r || o.er !== e) begin
            failures++;
            $display("FAIL random dut%0d we=%0d f3=%0d addr=%h rdata=%h err=%b required rdata=%h err=%b",
                     d, we, f3, a, o.rd, o.er, r, e);
         end
         checks++;
         if (o.lat !== wc(d) + 1 || !o.rdy_low || !o.after_ok) begin
            failures++;
            $display("FAIL random_timing dut%0d lat=%0d rdy_low=%b after_ok=%b required lat=%0d",
                     d, o.lat, o.rdy_low, o.after_ok, wc(d) + 1);
         end
      end
   endtask

   // A request held valid throughout is accepted once every WAIT_CYCLES+2 cycles.
   task automatic test_back_to_back(input int d);
      int per;
      bit [31:0] r;
      bit e;
      per = wc(d) + 2;
      model_access(d, 1'b0, 3'd2, 32'h4, 32'h0, r, e);
      req_valid[d] = 1'b1; req_we[d] = 1'b0; req_funct3[d] = 3'd2;
      req_addr[d] = 32'h4; req_wdata[d] = 32'h0;
      for (int j = 0; j < 4 * per; j++) begin
         checks++;
         if (req_ready[d] !== (j % per == 0) || rsp_valid[d] !== (j % per == per - 1)) begin
            failures++;
            $display("FAIL b2b dut%0d cycle=%0d ready=%b valid=%b required ready=%b valid=%b",
                     d, j, req_ready[d], rsp_valid[d], (j % per == 0), (j % per == per - 1));
         end
         if (j % per == per - 1) begin
            checks++;
            if (rsp_rdata[d] !== r) begin
               failures++;
               $display("FAIL b2b_data dut%0d cycle=%0d rdata=%h required %h", d, j, rsp_rdata[d], r);
            end
         end
         @(posedge clk); #1;
      end
      req_valid[d] = 1'b0;
   endtask

   task automatic test_reset_in_wait();
      obs_t o;
      bit [31:0] r;
      bit e;
      int seen = 0;
      do_req(1, 1'b1, 3'd2, 32'h20, 32'h0, o);
      model_access(1, 1'b1, 3'd2, 32'h20, 32'h0, r, e);
      req_valid[1] = 1'b1; req_we[1] = 1'b1; req_funct3[1] = 3'd2;
      req_addr[1] = 32'h20; req_wdata[1] = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      @(posedge clk); #1;
      rst_n[1] = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         if (rsp_valid[1]) seen++;
      end
      rst_n[1] = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (rsp_valid[1]) seen++;
         @(posedge clk); #1;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL reset_wait_rsp dut1 rsp_valid seen %0d cycles required 0", seen);
      end
      do_req(1, 1'b0, 3'd2, 32'h120, 32'h0, o);
      checks++;
      if (o.rd !== 32'h0 || o.er !== 1'b0) begin
         failures++;
         $display("FAIL reset_wait_data rdata=%h err=%b required rdata=00000000 err=0", o.rd, o.er);
      end
      // Reset landing in RESP must drop the strobe at once.
      req_valid[1] = 1'b1; req_we[1] = 1'b0; req_funct3[1] = 3'd2; req_addr[1] = 32'h0;
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      for (int c = 0; c < 10 && !rsp_valid[1]; c++) begin
         @(posedge clk); #1;
      end
      #1 rst_n[1] = 1'b0;
      #1;
      checks++;
      if (rsp_valid[1] !== 1'b0) begin
         failures++;
         $display("FAIL reset_resp rsp_valid=%b required 0", rsp_valid[1]);
      end
      @(posedge clk); #1;
      rst_n[1] = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      for (int d = 0; d < 2; d++)
         for (int b = 0; b < 256; b++) mdl[d][b] = 8'h00;
      test_reset();
      init_mem();
      test_directed();
      test_misalign();
      test_random(0, 80);
      test_random(1, 60);
      test_back_to_back(0);
      test_back_to_back(1);
      test_reset_in_wait();
      test_random(1, 20);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
